// File: rtl/bitscan_if.sv
// ---------------------------------------------------------------------------
// bitscan_if
// Request/response bundle for bitscan_pipe. The signal names are written from
// the unit's point of view: i_* signals flow into the unit and o_* signals
// flow out of it.
//   slave  : the bit-scan unit itself
//   master : the requester/consumer (ALU issue logic or allocator)
// Request side  : i_valid, o_ready, i_op, i_w32, i_data, i_tag, i_flush
// Response side : o_valid, i_ready, o_result, o_zero, o_illegal, o_tag
// ---------------------------------------------------------------------------
interface bitscan_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8,
  parameter int RES_W = $clog2(WIDTH) + 1
) ();
  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic             i_w32;
  logic [WIDTH-1:0] i_data;
  logic [TAG_W-1:0] i_tag;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic [RES_W-1:0] o_result;
  logic             o_zero;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;

  modport slave (
    input  i_valid, i_op, i_w32, i_data, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_zero, o_illegal, o_tag
  );

  modport master (
    output i_valid, i_op, i_w32, i_data, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_zero, o_illegal, o_tag
  );
endinterface

// File: rtl/bitscan_pipe.sv
// ---------------------------------------------------------------------------
// bitscan_pipe
// Pipelined popcount / leading-zero / trailing-zero / highest-set-index /
// trailing-ones-run unit with an RV64 word (32-bit) mode.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous, active-low reset
//   bus  : bitscan_if.slave. Valid/ready request with op, w32, data and tag.
//          Valid/ready response with result, zero, illegal and tag.
//          i_flush kills every in-flight op.
// The whole evaluation happens ahead of stage 0. The STAGES register stages
// form an elastic queue: a stage loads whenever it is empty or its content is
// leaving this cycle. This gives one op per cycle with no bubbles and lets the
// unit hold up to STAGES results under backpressure.
// ---------------------------------------------------------------------------
module bitscan_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 8,
  parameter int RES_W  = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst,
  bitscan_if.slave bus
);

  typedef enum logic [2:0] {
    OP_CPOP     = 3'd0,
    OP_CLZ      = 3'd1,
    OP_CTZ      = 3'd2,
    OP_LAST_ONE = 3'd3,
    OP_RUN_ONE  = 3'd4
  } op_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  // Word mode only exists when the operand is wider than a word.
  localparam bit HAS_WORD = (WIDTH > 32);

  logic             w_word;
  logic [RES_W-1:0] w_ew;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_inv;
  logic [RES_W-1:0] w_cpop;
  logic [RES_W-1:0] w_last;
  logic [RES_W-1:0] w_ctz;
  logic [RES_W-1:0] w_run;
  logic [RES_W-1:0] w_clz;
  stage_t           w_new;

  // ---------------------------------------------------------------- evaluate
  // NOTE: every variable written in this block receives a value before it is
  // read on every path, so the block stays purely combinational (no latches).
  always_comb begin
    w_word = HAS_WORD && bus.i_w32;
    w_ew   = w_word ? RES_W'(32) : RES_W'(WIDTH);
    // w_d is the effective operand. w_inv is its complement inside the
    // effective width, so the ones-run is simply the trailing-zero count of
    // w_inv.
    for (int i = 0; i < WIDTH; i++) begin
      w_d[i]   =  bus.i_data[i] && !(w_word && (i >= 32));
      w_inv[i] = !bus.i_data[i] && !(w_word && (i >= 32));
    end
    w_cpop = '0;
    w_last = '0;
    w_ctz  = w_ew;
    w_run  = w_ew;
    // In the ascending scan the last hit wins (the highest set bit). In the
    // descending scan the last hit is the lowest set bit.
    for (int i = 0; i < WIDTH; i++) begin
      w_cpop = w_cpop + RES_W'(w_d[i]);
      if (w_d[i]) w_last = RES_W'(i + 1);
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_d[i])   w_ctz = RES_W'(i);
      if (w_inv[i]) w_run = RES_W'(i);
    end
    // The leading-zero count is measured from bit EW-1, so it is the
    // complement of the highest-set index within EW.
    w_clz = w_ew - w_last;

    w_new.zero    = (w_d == '0);
    w_new.illegal = 1'b0;
    w_new.tag     = bus.i_tag;
    case (bus.i_op)
      OP_CPOP:     w_new.result = w_cpop;
      OP_CLZ:      w_new.result = w_clz;
      OP_CTZ:      w_new.result = w_ctz;
      OP_LAST_ONE: w_new.result = w_last;
      OP_RUN_ONE:  w_new.result = w_run;
      default: begin
        w_new.result  = '0;
        w_new.illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------- pipeline
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_take;
  logic [STAGES-1:0] w_in_vld;
  stage_t            r_stg    [STAGES];
  stage_t            w_in_stg [STAGES];

  always_comb begin : pipe_ctrl
    logic v_room;
    // Stage k may load when the consumer is ready or any stage at or beyond
    // k is empty. A hole further down lets the whole tail slide forward.
    v_room = bus.i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_room    = v_room || !r_vld[k];
      w_take[k] = v_room;
    end
    w_in_vld[0] = bus.i_valid;
    w_in_stg[0] = w_new;
    for (int k = 1; k < STAGES; k++) begin
      w_in_vld[k] = r_vld[k-1];
      w_in_stg[k] = r_stg[k-1];
    end
  end

  // NOTE: the stage payload registers are reset together with the valid
  // bits, because the outputs must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // stage samples its upstream value from before this edge.
      for (int k = 0; k < STAGES; k++) begin
        if (bus.i_flush)    r_vld[k] <= 1'b0;
        else if (w_take[k]) r_vld[k] <= w_in_vld[k];
        // The payload is held while stalled, which keeps the outputs stable
        // under backpressure.
        if (w_take[k] && w_in_vld[k]) r_stg[k] <= w_in_stg[k];
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  // During a flush the request is taken and then discarded, so ready is high.
  assign bus.o_ready   = w_take[0] || bus.i_flush;
  assign bus.o_valid   = r_vld[STAGES-1];
  assign bus.o_result  = r_stg[STAGES-1].result;
  assign bus.o_zero    = r_stg[STAGES-1].zero;
  assign bus.o_illegal = r_stg[STAGES-1].illegal;
  assign bus.o_tag     = r_stg[STAGES-1].tag;

endmodule

// File: tb/tb_bitscan_pipe.sv
// ---------------------------------------------------------------------------
// tb_bitscan_pipe
// Self-checking bench for bitscan_pipe (WIDTH=64, STAGES=2). Expected records
// are pushed to a scoreboard when an op is accepted. They are popped and
// compared by a monitor on every output handshake.
// ---------------------------------------------------------------------------
module tb_bitscan_pipe;
  localparam int WIDTH  = 64;
  localparam int STAGES = 2;
  localparam int TAG_W  = 8;
  localparam int RES_W  = 7;

  localparam logic [2:0] CPOP = 3'd0, CLZ = 3'd1, CTZ = 3'd2,
                         LAST = 3'd3, RUN = 3'd4;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic             zero;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic             w32;
    logic [63:0]      data;
    logic [RES_W-1:0] res;
    logic             zero;
    logic             ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitscan_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
  bitscan_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_acc   = 0;
  int   n_out   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference model: straightforward bit walks over the effective operand.
  function automatic exp_t model(input logic [2:0] op, input logic w32,
                                 input logic [63:0] data, input logic [7:0] tag);
    exp_t        e;
    logic [63:0] d;
    int          ew, pop, lead, low, run, i, r;
    ew = w32 ? 32 : 64;
    d  = data;
    if (w32) d[63:32] = '0;
    pop = 0;
    for (int b = 0; b < ew; b++) if (d[b]) pop++;
    lead = 0;
    i    = ew - 1;
    while (i >= 0 && !d[i]) begin lead++; i--; end
    low = 0;
    while (low < ew && !d[low]) low++;
    run = 0;
    while (run < ew && d[run]) run++;
    e.zero = (d == 64'd0);
    e.ill  = 1'b0;
    e.tag  = tag;
    case (op)
      3'd0:    r = pop;
      3'd1:    r = lead;
      3'd2:    r = low;
      3'd3:    r = (d == 64'd0) ? 0 : ew - lead;
      3'd4:    r = run;
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    e.res = RES_W'(r);
    return e;
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.o_valid && bus.i_ready) begin
      n_out++;
      if (sb.size() == 0) fail($sformatf("unexpected_output tag=%0h", bus.o_tag));
      else begin
        e = sb.pop_front();
        check($sformatf("out_tag%0h_result", e.tag),  bus.o_result,  e.res);
        check($sformatf("out_tag%0h_zero", e.tag),    bus.o_zero,    e.zero);
        check($sformatf("out_tag%0h_illegal", e.tag), bus.o_illegal, e.ill);
        check("out_tag_order", bus.o_tag, e.tag);
      end
    end
  end

  // Drives one request and holds it until it is accepted. The accept cycle is
  // the cycle before the capturing edge.
  task automatic issue(input logic [2:0] op, input logic w32, input logic [63:0] data,
                       input logic [7:0] tag, input bit push, input exp_t e,
                       output int acc_cyc);
    int n;
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_w32   = w32;
    bus.i_data  = data;
    bus.i_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin @(negedge clk); n++; end
    acc_cyc = cyc;
    if (!bus.o_ready) fail($sformatf("accept_timeout tag=%0h", tag));
    else begin
      if (push) sb.push_back(e);
      n_acc++;
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic w32, input logic [63:0] data,
                      input logic [7:0] tag, output int acc_cyc);
    issue(op, w32, data, tag, 1'b1, model(op, w32, data, tag), acc_cyc);
  endtask

  task automatic wait_valid(input int acc_cyc, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_valid) fail({name, "_timeout"});
    else check(name, 64'(cyc - acc_cyc), 64'(STAGES));
  endtask

  task automatic drain();
    int n;
    bus.i_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (sb.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input string name, input logic [2:0] op, input logic w32,
                         input logic [63:0] data, input int res, input logic zero,
                         input logic ill);
    vec_t v;
    v.name = name; v.op = op; v.w32 = w32; v.data = data;
    v.res = RES_W'(res); v.zero = zero; v.ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, acc0, out0;
    bit   done;
    exp_t e;
    logic [63:0] d;

    add_vec("cpop_mix",      CPOP, 1'b0, 64'hFFFF_0000_0000_0001, 17, 1'b0, 1'b0);
    add_vec("clz_zero",      CLZ,  1'b0, 64'h0,                   64, 1'b1, 1'b0);
    add_vec("ctz_80",        CTZ,  1'b0, 64'h80,                   7, 1'b0, 1'b0);
    add_vec("last_msb",      LAST, 1'b0, 64'h8000_0000_0000_0000, 64, 1'b0, 1'b0);
    add_vec("run_0f",        RUN,  1'b0, 64'h0F,                   4, 1'b0, 1'b0);
    add_vec("run_ones",      RUN,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 1'b0);
    add_vec("last_zero",     LAST, 1'b0, 64'h0,                    0, 1'b1, 1'b0);
    add_vec("ctz_zero",      CTZ,  1'b0, 64'h0,                   64, 1'b1, 1'b0);
    add_vec("cpop_ones",     CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0, 1'b0);
    add_vec("w32_clz",       CLZ,  1'b1, 64'hFFFF_FFFF_0000_0001, 31, 1'b0, 1'b0);
    add_vec("w32_cpop",      CPOP, 1'b1, 64'hFFFF_FFFF_0000_0001,  1, 1'b0, 1'b0);
    add_vec("w32_ctz",       CTZ,  1'b1, 64'hFFFF_FFFF_0000_0001,  0, 1'b0, 1'b0);
    add_vec("w32_clz_zero",  CLZ,  1'b1, 64'hFFFF_FFFF_0000_0000, 32, 1'b1, 1'b0);
    add_vec("w32_run_ones",  RUN,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 32, 1'b0, 1'b0);
    add_vec("w32_last_zero", LAST, 1'b1, 64'hFFFF_FFFF_0000_0000,  0, 1'b1, 1'b0);
    add_vec("illegal_7",     3'd7, 1'b0, 64'h5,                    0, 1'b0, 1'b1);
    add_vec("illegal_5",     3'd5, 1'b0, 64'h0,                    0, 1'b1, 1'b1);

    bus.i_valid = 1'b0; bus.i_op = '0; bus.i_w32 = 1'b0; bus.i_data = '0;
    bus.i_tag = '0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_o_valid",   bus.o_valid,   1'b0);
    check("reset_o_result",  bus.o_result,  '0);
    check("reset_o_zero",    bus.o_zero,    1'b0);
    check("reset_o_illegal", bus.o_illegal, 1'b0);
    check("reset_o_tag",     bus.o_tag,     '0);
    rst = 1'b1;
    #1 check("reset_o_ready", bus.o_ready, 1'b1);
    @(posedge clk); #1;

    // First op: latency and result
    send(CPOP, 1'b0, 64'hFFFF_0000_0000_0001, 8'hA5, acc);
    wait_valid(acc, "cpop_latency");
    check("cpop_first_result", bus.o_result, 7'd17);
    check("cpop_first_zero",   bus.o_zero,   1'b0);
    @(posedge clk); #1;

    // Table vectors streamed back-to-back
    for (int i = 0; i < vecs.size(); i++) begin
      e.res = vecs[i].res; e.zero = vecs[i].zero; e.ill = vecs[i].ill; e.tag = 8'(i);
      issue(vecs[i].op, vecs[i].w32, vecs[i].data, 8'(i), 1'b1, e, acc);
    end
    drain();

    // Backpressure: 5 CPOPs (tag t has 3t ones), consumer stalled at first
    bus.i_ready = 1'b0;
    acc0 = n_acc;
    out0 = n_out;
    fork
      begin
        int a;
        for (int t = 1; t <= 5; t++) send(CPOP, 1'b0, (64'h1 << (3 * t)) - 64'h1, 8'(t), a);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
        repeat (3) begin
          @(negedge clk);
          check("bp_valid_held",  bus.o_valid,  1'b1);
          check("bp_ready_low",   bus.o_ready,  1'b0);
          check("bp_tag_held",    bus.o_tag,    8'd1);
          check("bp_result_held", bus.o_result, 7'd3);
        end
        check("bp_buffered_count", 64'(n_acc - acc0), 64'd2);
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered_count", 64'(n_out - out0), 64'd5);

    // Flush: two ops in flight, a third offered in the flush cycle
    bus.i_ready = 1'b0;
    e = '0;
    issue(CLZ, 1'b0, 64'h1, 8'hF1, 1'b0, e, acc);
    issue(CTZ, 1'b0, 64'h2, 8'hF2, 1'b0, e, acc);
    bus.i_valid = 1'b1; bus.i_op = CPOP; bus.i_data = 64'h3; bus.i_tag = 8'hF3;
    bus.i_flush = 1'b1;
    @(negedge clk);
    check("flush_o_ready", bus.o_ready, 1'b1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
    @(negedge clk);
    check("flush_o_valid_next", bus.o_valid, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("flush_stays_empty", bus.o_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(LAST, 1'b0, 64'h0000_0100_0000_0000, 8'h44, acc);
    wait_valid(acc, "post_flush_latency");
    @(posedge clk); #1;
    drain();

    // Asynchronous reset with ops in flight
    bus.i_ready = 1'b0;
    issue(CPOP, 1'b0, 64'hFF, 8'h77, 1'b0, e, acc);
    issue(RUN,  1'b0, 64'h7,  8'h78, 1'b0, e, acc);
    check("rst_pre_valid", bus.o_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_o_valid",   bus.o_valid,   1'b0);
    check("rst_async_o_result",  bus.o_result,  '0);
    check("rst_async_o_zero",    bus.o_zero,    1'b0);
    check("rst_async_o_illegal", bus.o_illegal, 1'b0);
    check("rst_async_o_tag",     bus.o_tag,     '0);
    @(posedge clk); #3;
    rst = 1'b1;
    bus.i_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_stale", bus.o_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(CTZ, 1'b0, 64'h0010_0000_0000_0000, 8'h55, acc);
    wait_valid(acc, "post_reset_latency");
    @(posedge clk); #1;
    drain();

    // Random ops against the model with a randomly stalling consumer
    done = 1'b0;
    fork
      begin
        int a;
        for (int i = 0; i < 40; i++) begin
          case ($urandom_range(0, 3))
            0:       d = {$urandom, $urandom};
            1:       d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            2:       d = (64'h1 << $urandom_range(0, 63)) - 64'h1;
            default: d = ($urandom_range(0, 1) == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
          endcase
          send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), d, 8'(i + 8'h80), a);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
